// File: rtl/audio_avg_filter.sv
// ============================================================================
// Module   : audio_avg_filter
// Purpose  : Stereo moving-average low-pass between CODEC read and write side.
//            Optional macro AVG_BYPASS_EN adds a raw-sample bypass input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_avg_filter #(
  parameter int DATA_W    = 24,
  parameter int LOG2_TAPS = 3
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
`ifdef AVG_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  input  logic              write_ready,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right
);

  localparam int c_TAPS  = 2 ** LOG2_TAPS;
  localparam int c_SUM_W = DATA_W + LOG2_TAPS;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ACC  = 3'd2,
    S_OUT  = 3'd3,
    S_WAIT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_read_nxt, w_write_nxt, w_cap, w_acc, w_load;
  logic r_read, r_write;

  logic        [DATA_W-1:0]    r_new_l, r_new_r;
  logic        [DATA_W-1:0]    r_wd_l, r_wd_r;
  logic        [LOG2_TAPS-1:0] r_ptr;
  logic signed [c_SUM_W-1:0]   r_sum_l, r_sum_r;
  logic        [DATA_W-1:0]    r_hist_l [c_TAPS];
  logic        [DATA_W-1:0]    r_hist_r [c_TAPS];

  logic signed [c_SUM_W-1:0] w_new_l_ext, w_new_r_ext, w_old_l_ext, w_old_r_ext;
  logic signed [c_SUM_W-1:0] w_sum_l_nxt, w_sum_r_nxt;
  logic        [DATA_W-1:0]  w_out_l, w_out_r;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_read_nxt  = 1'b0;
    w_write_nxt = 1'b0;
    w_cap       = 1'b0;
    w_acc       = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: if (read_ready) begin
        w_read_nxt  = 1'b1;
        w_state_nxt = S_REQ;
      end
      // Pop strobe is high this cycle, so the CODEC still presents the head pair.
      S_REQ: begin
        w_cap       = 1'b1;
        w_state_nxt = S_ACC;
      end
      S_ACC: begin
        w_acc       = 1'b1;
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        w_load      = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: if (write_ready) begin
        w_write_nxt = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Running sum is the exact total of the window, so it never needs saturation.
  assign w_new_l_ext = {{LOG2_TAPS{r_new_l[DATA_W-1]}}, r_new_l};
  assign w_new_r_ext = {{LOG2_TAPS{r_new_r[DATA_W-1]}}, r_new_r};
  assign w_old_l_ext = {{LOG2_TAPS{r_hist_l[r_ptr][DATA_W-1]}}, r_hist_l[r_ptr]};
  assign w_old_r_ext = {{LOG2_TAPS{r_hist_r[r_ptr][DATA_W-1]}}, r_hist_r[r_ptr]};
  assign w_sum_l_nxt = r_sum_l + w_new_l_ext - w_old_l_ext;
  assign w_sum_r_nxt = r_sum_r + w_new_r_ext - w_old_r_ext;

  // Dropping the low LOG2_TAPS bits is the arithmetic shift (floor divide by TAPS).
`ifdef AVG_BYPASS_EN
  assign w_out_l = bypass ? r_new_l : r_sum_l[LOG2_TAPS +: DATA_W];
  assign w_out_r = bypass ? r_new_r : r_sum_r[LOG2_TAPS +: DATA_W];
`else
  assign w_out_l = r_sum_l[LOG2_TAPS +: DATA_W];
  assign w_out_r = r_sum_r[LOG2_TAPS +: DATA_W];
`endif

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_new_l <= '0;
      r_new_r <= '0;
      r_wd_l  <= '0;
      r_wd_r  <= '0;
      r_ptr   <= '0;
      r_sum_l <= '0;
      r_sum_r <= '0;
      for (int i = 0; i < c_TAPS; i++) begin
        r_hist_l[i] <= '0;
        r_hist_r[i] <= '0;
      end
    end else begin
      r_read  <= w_read_nxt;
      r_write <= w_write_nxt;
      if (w_cap) begin
        r_new_l <= readdata_left;
        r_new_r <= readdata_right;
      end
      if (w_acc) begin
        r_sum_l         <= w_sum_l_nxt;
        r_sum_r         <= w_sum_r_nxt;
        r_hist_l[r_ptr] <= r_new_l;
        r_hist_r[r_ptr] <= r_new_r;
        r_ptr           <= r_ptr + 1'b1;
      end
      if (w_load) begin
        r_wd_l <= w_out_l;
        r_wd_r <= w_out_r;
      end
    end
  end

  assign read            = r_read;
  assign write           = r_write;
  assign writedata_left  = r_wd_l;
  assign writedata_right = r_wd_r;

endmodule

`default_nettype wire
